// File: rtl/serial_reg_file.sv
// serial_reg_file: slice-serial register file with its own slice sequencer.
// Two prefetched read ports and one write port move SLICE_W bits per cycle.
module serial_reg_file #(
  parameter int XLEN     = 32,
  parameter int SLICE_W  = 8,
  parameter int NUM_REGS = 16,
  parameter int ZERO_REG = 1,
  localparam int NSLICE  = XLEN / SLICE_W,
  localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
  localparam int SW      = $clog2(NSLICE)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stall,
  input  logic [AW-1:0]      rs1,
  input  logic [AW-1:0]      rs2,
  input  logic [AW-1:0]      rd,
  input  logic               rd_we,
  input  logic [SLICE_W-1:0] rd_dat,
  output logic [SLICE_W-1:0] rs1_dat,
  output logic [SLICE_W-1:0] rs2_dat,
  output logic [SW-1:0]      slice_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q, state_d;
  logic [SW-1:0]      idx_q, idx_d;
  logic [AW-1:0]      rs1_addr_q, rs1_addr_d;
  logic [AW-1:0]      rs2_addr_q, rs2_addr_d;
  logic [AW-1:0]      rd_addr_q, rd_addr_d;
  logic               rd_we_q, rd_we_d;
  logic [SLICE_W-1:0] rs1_dat_q, rs1_dat_d;
  logic [SLICE_W-1:0] rs2_dat_q, rs2_dat_d;
  logic [XLEN-1:0]    regs_q [NUM_REGS];

  logic run_active, last, accept, wr_en;

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [SLICE_W-1:0] read_slice(input logic [AW-1:0] a,
                                                    input logic [SW-1:0] k);
    if (!addr_ok(a) || is_zero_reg(a)) return '0;
    return regs_q[a][k*SLICE_W +: SLICE_W];
  endfunction

  assign run_active = (state_q == RUN) && !stall;
  assign last       = (idx_q == SW'(NSLICE - 1));
  assign accept     = start && !stall && ((state_q == IDLE) || ((state_q == RUN) && last));
  assign wr_en      = run_active && rd_we_q && addr_ok(rd_addr_q) && !is_zero_reg(rd_addr_q);

  // NOTE: every next-state signal is defaulted to its current value first, so no path through
  // this block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    rd_we_d    = rd_we_q;
    rs1_dat_d  = rs1_dat_q;
    rs2_dat_d  = rs2_dat_q;
    if (accept) begin
      // Slice 0 is fetched with the live input addresses; the latched copies serve later slices.
      state_d    = RUN;
      idx_d      = '0;
      rs1_addr_d = rs1;
      rs2_addr_d = rs2;
      rd_addr_d  = rd;
      rd_we_d    = rd_we;
      rs1_dat_d  = read_slice(rs1, '0);
      rs2_dat_d  = read_slice(rs2, '0);
    end else if (run_active) begin
      if (last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d     = idx_q + 1'b1;
        rs1_dat_d = read_slice(rs1_addr_q, idx_q + 1'b1);
        rs2_dat_d = read_slice(rs2_addr_q, idx_q + 1'b1);
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
      rs1_dat_q  <= '0;
      rs2_dat_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      rd_we_q    <= rd_we_d;
      rs1_dat_q  <= rs1_dat_d;
      rs2_dat_q  <= rs2_dat_d;
    end
  end

  // NOTE: the storage array is cleared in reset because the file must read as zero afterwards;
  // this keeps it in flops rather than letting it map onto a RAM macro.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[rd_addr_q][idx_q*SLICE_W +: SLICE_W] <= rd_dat;
    end
  end

  assign rs1_dat   = rs1_dat_q;
  assign rs2_dat   = rs2_dat_q;
  assign slice_idx = idx_q;
  assign busy      = (state_q == RUN);
  assign done      = run_active && last;

endmodule

// File: tb/tb_serial_reg_file.sv
// Directed self-checking bench for serial_reg_file; a second instance with ZERO_REG=0
// shares the stimulus so the register-0 behaviour can be compared.
module tb_serial_reg_file;

  localparam int AW = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          rd_we = 1'b0;
  logic [AW-1:0] rs1 = '0, rs2 = '0, rd = '0;
  logic [7:0]    rd_dat = '0;

  logic [7:0]    rs1_dat, rs2_dat, nz_rs1_dat, nz_rs2_dat;
  logic [SW-1:0] slice_idx, nz_slice_idx;
  logic          busy, done, nz_busy, nz_done;

  int passed = 0;
  int total  = 0;

  logic [7:0] pat_x5 [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
  logic [7:0] pat_x9 [4] = '{8'hBE, 8'hBA, 8'hFE, 8'hCA};

  always #5 clk = ~clk;

  serial_reg_file #(.XLEN(32), .SLICE_W(8), .NUM_REGS(16), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .rd_dat(rd_dat),
    .rs1_dat(rs1_dat), .rs2_dat(rs2_dat), .slice_idx(slice_idx),
    .busy(busy), .done(done)
  );

  serial_reg_file #(.XLEN(32), .SLICE_W(8), .NUM_REGS(16), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_we(rd_we), .rd_dat(rd_dat),
    .rs1_dat(nz_rs1_dat), .rs2_dat(nz_rs2_dat), .slice_idx(nz_slice_idx),
    .busy(nz_busy), .done(nz_done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic chk_main(input string tag, input logic eb, input logic ed,
                          input logic [SW-1:0] ei, input logic [7:0] e1, input logic [7:0] e2);
    check({tag, ".busy"},      32'(busy),      32'(eb));
    check({tag, ".done"},      32'(done),      32'(ed));
    check({tag, ".slice_idx"}, 32'(slice_idx), 32'(ei));
    check({tag, ".rs1_dat"},   32'(rs1_dat),   32'(e1));
    check({tag, ".rs2_dat"},   32'(rs2_dat),   32'(e2));
  endtask

  // One clock cycle: drive, let combinational outputs settle, compare, then advance.
  task automatic cyc(input string tag, input logic st, input logic sl, input logic [7:0] d,
                     input logic eb, input logic ed, input logic [SW-1:0] ei,
                     input logic [7:0] e1, input logic [7:0] e2);
    start  = st;
    stall  = sl;
    rd_dat = d;
    #1;
    chk_main(tag, eb, ed, ei, e1, e2);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset while idle.
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_main("rst", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    check("rst.nz_busy", 32'(nz_busy), 32'h0);
    rst = 1'b0;

    // Read of cleared registers x3/x7.
    rs1 = 4'd3; rs2 = 4'd7; rd = 4'd0; rd_we = 1'b0;
    cyc("t1.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t1.run%0d", k), 1'b0, 1'b0, 8'h00, 1'b1, k == 3, SW'(k), 8'h00, 8'h00);
    cyc("t1.idle", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);

    // Write x5 = 0x12345678, then read it back.
    rd = 4'd5; rd_we = 1'b1;
    cyc("t2w.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t2w.run%0d", k), 1'b0, 1'b0, pat_x5[k], 1'b1, k == 3, SW'(k), 8'h00, 8'h00);
    rs1 = 4'd5; rs2 = 4'd0; rd_we = 1'b0;
    cyc("t2r.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t2r.run%0d", k), 1'b0, 1'b0, 8'h00, 1'b1, k == 3, SW'(k), pat_x5[k], 8'h00);

    // Register 0: write 0xFF slices, then read on both instances.
    rs1 = 4'd0; rs2 = 4'd0; rd = 4'd0; rd_we = 1'b1;
    cyc("t3w.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h12, 8'h00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t3w.run%0d", k), 1'b0, 1'b0, 8'hFF, 1'b1, k == 3, SW'(k), 8'h00, 8'h00);
    rd_we = 1'b0;
    cyc("t3r.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++) begin
      start = 1'b0; stall = 1'b0; rd_dat = 8'h00;
      #1;
      chk_main($sformatf("t3r.run%0d", k), 1'b1, k == 3, SW'(k), 8'h00, 8'h00);
      check($sformatf("t3r.nz_rs1_dat%0d", k), 32'(nz_rs1_dat), 32'hFF);
      check($sformatf("t3r.nz_rs2_dat%0d", k), 32'(nz_rs2_dat), 32'hFF);
      @(posedge clk);
      #1;
    end

    // Stall: read x5 while writing x6; two stalls in RUN(1), one stall with start in RUN(3).
    rs1 = 4'd5; rs2 = 4'd6; rd = 4'd6; rd_we = 1'b1;
    cyc("t4.start",   1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    cyc("t4.run0",    1'b0, 1'b0, 8'hA0, 1'b1, 1'b0, 2'd0, 8'h78, 8'h00);
    cyc("t4.stall1a", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 2'd1, 8'h56, 8'h00);
    cyc("t4.stall1b", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 2'd1, 8'h56, 8'h00);
    cyc("t4.run1",    1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 2'd1, 8'h56, 8'h00);
    cyc("t4.run2",    1'b0, 1'b0, 8'hA2, 1'b1, 1'b0, 2'd2, 8'h34, 8'h00);
    cyc("t4.stall3",  1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 2'd3, 8'h12, 8'h00);
    cyc("t4.run3",    1'b0, 1'b0, 8'hA3, 1'b1, 1'b1, 2'd3, 8'h12, 8'h00);

    // Back-to-back: op A writes x9 and reads x6/x5; op B starts in A's done cycle and reads x9.
    rs1 = 4'd6; rs2 = 4'd5; rd = 4'd9; rd_we = 1'b1;
    cyc("t5a.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h12, 8'h00);
    cyc("t5a.run0",  1'b0, 1'b0, pat_x9[0], 1'b1, 1'b0, 2'd0, 8'hA0, 8'h78);
    cyc("t5a.run1",  1'b0, 1'b0, pat_x9[1], 1'b1, 1'b0, 2'd1, 8'hA1, 8'h56);
    cyc("t5a.run2",  1'b0, 1'b0, pat_x9[2], 1'b1, 1'b0, 2'd2, 8'hA2, 8'h34);
    rs1 = 4'd9; rs2 = 4'd9; rd = 4'd0; rd_we = 1'b0;
    cyc("t5a.run3",  1'b1, 1'b0, pat_x9[3], 1'b1, 1'b1, 2'd3, 8'hA3, 8'h12);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t5b.run%0d", k), 1'b0, 1'b0, 8'h00, 1'b1, k == 3, SW'(k), pat_x9[k], pat_x9[k]);

    // Reset in RUN(2) of a write to x4, then read x4/x9 after release.
    rs1 = 4'd9; rs2 = 4'd0; rd = 4'd4; rd_we = 1'b1;
    cyc("t6.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'hCA, 8'hCA);
    cyc("t6.run0",  1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 2'd0, 8'hBE, 8'h00);
    cyc("t6.run1",  1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 2'd1, 8'hBA, 8'h00);
    rd_dat = 8'h33;
    rst    = 1'b1;
    #1;
    chk_main("t6.rst", 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rs1 = 4'd4; rs2 = 4'd9; rd_we = 1'b0;
    cyc("t6r.start", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t6r.run%0d", k), 1'b0, 1'b0, 8'h00, 1'b1, k == 3, SW'(k), 8'h00, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
